// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl
//   Sequencer between the input cacheline FIFO and the convLayerFFT datapath.
//   Input lines are popped only while the output FIFO is guaranteed room for
//   every result already in flight (credit scheme), so a full output FIFO can
//   never drop datapath output. One result cacheline per input cacheline.
//
// Optional feature: define CONV_CTRL_TIMEOUT_EN to enable the drain watchdog
//   (TIMEOUT_CYCLES consecutive DRAIN cycles without a result ends the job
//   with timeout and err set). Undefined: no watchdog, timeout tied 0.
//
// Ports:
//   clk             clock
//   reset           asynchronous reset, active-low
//   start           single-cycle pulse, begins a job (ignored while busy)
//   ctx_length      job length in cachelines, sampled on an accepted start
//   in_fifo_empty   input FIFO empty
//   in_fifo_re      input FIFO pop / datapath input_valid (combinational)
//   dp_output_valid datapath produced one result (output FIFO write)
//   out_fifo_count  output FIFO occupancy, 0..2**OUT_DEPTH_BITS
//   busy            job in RUN or DRAIN
//   done            job complete, held until the next accepted start
//   err             sticky protocol error
//   lines_issued    cachelines popped this job
//   lines_retired   results received this job
//   timeout         drain watchdog fired
module conv_stream_ctrl #(
    parameter int unsigned OUT_DEPTH_BITS = 3,
    parameter int unsigned LEN_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    ctx_length,
    input  logic                    in_fifo_empty,
    output logic                    in_fifo_re,
    input  logic                    dp_output_valid,
    input  logic [OUT_DEPTH_BITS:0] out_fifo_count,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [LEN_WIDTH-1:0]    lines_issued,
    output logic [LEN_WIDTH-1:0]    lines_retired,
    output logic                    timeout
);

    localparam int unsigned CAP = 2 ** OUT_DEPTH_BITS;
    localparam logic [OUT_DEPTH_BITS+1:0] CAP_W = (OUT_DEPTH_BITS + 2)'(CAP);

    // Elaboration-time sanity checks on the configuration.
    if (OUT_DEPTH_BITS == 0) begin : g_bad_depth
        $error("conv_stream_ctrl: OUT_DEPTH_BITS must be at least 1");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("conv_stream_ctrl: TIMEOUT_CYCLES must be nonzero");
    end

    // LAUNCH_EMPTY is the one-cycle hop taken by a zero-length job so that it
    // reaches DONE on the cycle after the start is accepted, never via RUN.
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        LAUNCH_EMPTY,
        DONE
    } state_t;

    state_t                  state;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [OUT_DEPTH_BITS:0] inflight;

    logic [OUT_DEPTH_BITS+1:0] occupancy;
    logic                      credit_ok;
    logic                      pop;
    logic                      ret;
    logic                      spurious;
    logic [LEN_WIDTH-1:0]      issued_nxt;
    logic [LEN_WIDTH-1:0]      retired_nxt;

    // Results already in flight will land in the output FIFO; counting them
    // against capacity guarantees every result has a slot when it arrives.
    assign occupancy   = {1'b0, out_fifo_count} + {1'b0, inflight};
    assign credit_ok   = occupancy < CAP_W;
    assign pop         = (state == RUN) && !in_fifo_empty &&
                         (lines_issued < len_q) && credit_ok;
    assign in_fifo_re  = pop;
    assign ret         = dp_output_valid && (inflight != '0);
    assign spurious    = dp_output_valid && (inflight == '0);
    assign issued_nxt  = lines_issued + LEN_WIDTH'(1);
    assign retired_nxt = lines_retired + LEN_WIDTH'(1);

`ifdef CONV_CTRL_TIMEOUT_EN
    logic [31:0] wd_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            len_q         <= '0;
            inflight      <= '0;
            lines_issued  <= '0;
            lines_retired <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
`ifdef CONV_CTRL_TIMEOUT_EN
            wd_cnt        <= '0;
            timeout       <= 1'b0;
`endif
        end else begin
            // Pop and retire in the same cycle leave inflight unchanged.
            case ({pop, ret})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
            if (pop) lines_issued <= issued_nxt;
            if (ret) lines_retired <= retired_nxt;
            if (spurious) err <= 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_q         <= ctx_length;
                        inflight      <= '0;
                        lines_issued  <= '0;
                        lines_retired <= '0;
                        err           <= spurious;
                        done          <= 1'b0;
`ifdef CONV_CTRL_TIMEOUT_EN
                        wd_cnt        <= '0;
                        timeout       <= 1'b0;
`endif
                        if (ctx_length != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= LAUNCH_EMPTY;
                            busy  <= 1'b0;
                        end
                    end
                end

                LAUNCH_EMPTY: begin
                    state <= DONE;
                    done  <= 1'b1;
                end

                RUN: begin
                    if (pop && (issued_nxt == len_q)) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (ret && (retired_nxt == len_q)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
`ifdef CONV_CTRL_TIMEOUT_EN
                    else if (ret) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        timeout <= 1'b1;
                        wd_cnt  <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Scoreboard bench for conv_stream_ctrl: the stimulus pushes each job's
// expected final counters/flags; a monitor pops and compares on every rising
// edge of done. Input FIFO, datapath pipeline and output FIFO are modelled.
module tb_conv_stream_ctrl;

    localparam int unsigned OBITS = 3;
    localparam int unsigned LW    = 32;
    localparam int unsigned TO    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] ctx_length;
    logic          in_fifo_empty;
    logic          in_fifo_re;
    logic          dp_output_valid;
    logic [OBITS:0] out_fifo_count;
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] lines_issued;
    logic [LW-1:0] lines_retired;
    logic          timeout;

    conv_stream_ctrl #(
        .OUT_DEPTH_BITS(OBITS),
        .LEN_WIDTH(LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ctx_length(ctx_length),
        .in_fifo_empty(in_fifo_empty),
        .in_fifo_re(in_fifo_re),
        .dp_output_valid(dp_output_valid),
        .out_fifo_count(out_fifo_count),
        .busy(busy),
        .done(done),
        .err(err),
        .lines_issued(lines_issued),
        .lines_retired(lines_retired),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned issued;
        int unsigned retired;
        logic        err;
        logic        tmo;
    } exp_t;
    exp_t exp_q[$];

    // Environment model state
    int in_count;
    int out_count;
    bit pipe[32];
    int lat;
    bit drain_en;
    int cyc = 0;
    int pops;
    int rets;
    int first_pop;
    int last_pop;
    int last_dpv;
    int done_cyc;
    int drop_after;
    int delivered;
    bit inv_chk;

    assign in_fifo_empty  = (in_count == 0);
    assign out_fifo_count = out_count[OBITS:0];

    function automatic void chk(string name, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    task automatic env_clear();
        in_count   = 0;
        out_count  = 0;
        for (int i = 0; i < 32; i++) pipe[i] = 1'b0;
        dp_output_valid = 1'b0;
        lat        = 3;
        drain_en   = 1'b1;
        pops       = 0;
        rets       = 0;
        first_pop  = -1;
        last_pop   = -1;
        last_dpv   = -1;
        done_cyc   = -1;
        drop_after = -1;
        delivered  = 0;
        inv_chk    = 1'b0;
    endtask

    // One clock: sample DUT-facing signals mid-cycle, then update the models
    // just after the rising edge.
    task automatic tick();
        bit p;
        bit v;
        @(negedge clk);
        p = in_fifo_re;
        v = dp_output_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (p) begin
            in_count--;
            pops++;
            if (first_pop < 0) first_pop = cyc - 1;
            last_pop = cyc - 1;
        end
        if (v) begin
            rets++;
            out_count++;
            last_dpv = cyc - 1;
        end
        if (drain_en && out_count > 0) out_count--;
        for (int i = 31; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = p;
        if (pipe[lat-1] && (drop_after < 0 || delivered < drop_after)) begin
            dp_output_valid = 1'b1;
            delivered++;
        end else begin
            dp_output_valid = 1'b0;
        end
        if (inv_chk) chk("credit_bound", longint'(out_count + pops - rets <= 8), 1);
    endtask

    task automatic start_job(input int unsigned len, input bit push,
                             input int unsigned ei, input int unsigned er,
                             input bit ee, input bit et);
        exp_t e;
        ctx_length = len;
        start = 1'b1;
        if (push) begin
            e.issued  = ei;
            e.retired = er;
            e.err     = ee;
            e.tmo     = et;
            exp_q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        done_cyc = cyc;
        chk({name, "_done_reached"}, done, 1);
    endtask

    // Monitor: compare final job state against the scoreboard on done rising.
    initial begin
        logic dq;
        exp_t e;
        dq = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !dq) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("job_issued", lines_issued, e.issued);
                    chk("job_retired", lines_retired, e.retired);
                    chk("job_err", err, e.err);
                    chk("job_timeout", timeout, e.tmo);
                    chk("job_busy_low", busy, 0);
                end
            end
            dq = done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ctx_length = '0;
        env_clear();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_re", in_fifo_re, 0);
        chk("rst_issued", lines_issued, 0);
        chk("rst_retired", lines_retired, 0);
        chk("rst_timeout", timeout, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Spurious output in IDLE: sticky err, cleared by next accepted start
        dp_output_valid = 1'b1;
        tick();
        chk("spur_err", err, 1);
        chk("spur_retired", lines_retired, 0);
        repeat (3) tick();
        chk("spur_err_sticky", err, 1);
        env_clear();
        lat = 2;
        in_count = 1;
        start_job(1, 1'b1, 1, 1, 1'b0, 1'b0);
        chk("spur_err_cleared", err, 0);
        wait_done("spur_job", 40);

        // Basic job
        env_clear();
        lat = 3;
        in_count = 4;
        start_job(4, 1'b1, 4, 4, 1'b0, 1'b0);
        wait_done("basic", 60);
        chk("basic_pops", pops, 4);
        chk("basic_consecutive", last_pop - first_pop, 3);
        chk("basic_done_latency", done_cyc, last_dpv + 1);

        // Zero length
        env_clear();
        start_job(0, 1'b1, 0, 0, 1'b0, 1'b0);
        chk("zero_done_early", done, 0);
        chk("zero_busy_1", busy, 0);
        tick();
        chk("zero_done", done, 1);
        chk("zero_busy_2", busy, 0);
        chk("zero_pops", pops, 0);

        // Credit stall
        env_clear();
        lat = 5;
        drain_en = 1'b0;
        out_count = 6;
        in_count = 10;
        inv_chk = 1'b1;
        start_job(10, 1'b1, 10, 10, 1'b0, 1'b0);
        repeat (15) tick();
        chk("credit_pops_stalled", pops, 2);
        chk("credit_re_held", in_fifo_re, 0);
        drain_en = 1'b1;
        wait_done("credit", 300);
        chk("credit_pops_total", pops, 10);
        inv_chk = 1'b0;

        // Reset mid-job at issued=3
        env_clear();
        lat = 20;
        in_count = 8;
        start_job(8, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int n = 0; n < 20 && lines_issued != 3; n++) tick();
        chk("midrst_issued", lines_issued, 3);
        reset = 1'b0;
        #2;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_re", in_fifo_re, 0);
        chk("midrst_issued0", lines_issued, 0);
        chk("midrst_retired0", lines_retired, 0);
        env_clear();
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Start while busy is ignored
        env_clear();
        lat = 2;
        start_job(3, 1'b1, 3, 3, 1'b0, 1'b0);
        repeat (2) tick();
        ctx_length = 7;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_busy", busy, 1);
        chk("busy_start_issued", lines_issued, 0);
        in_count = 3;
        wait_done("busy_start", 50);

`ifdef CONV_CTRL_TIMEOUT_EN
        // Watchdog: last result withheld
        env_clear();
        lat = 2;
        in_count = 2;
        drop_after = 1;
        start_job(2, 1'b1, 2, 1, 1'b1, 1'b1);
        wait_done("timeout", 60);
        chk("timeout_flag", timeout, 1);
        env_clear();
        in_count = 1;
        start_job(1, 1'b1, 1, 1, 1'b0, 1'b0);
        chk("timeout_cleared", timeout, 0);
        wait_done("timeout_recover", 40);
`endif

        tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_stream_ctrl.md
Name: conv_stream_ctrl

Overview:
- Sequencer between the input cacheline FIFO and the convLayerFFT datapath.
- Pops input cachelines into the datapath only when the output FIFO is guaranteed room for every result already in flight. This is credit-based, so a full output FIFO never drops datapath output.
- Counts ctx_length cachelines issued and retired, and reports busy/done/error to the AFU control logic.
- One result cacheline per input cacheline (1:1).

Parameters:
- OUT_DEPTH_BITS, 3, log2 of output FIFO depth; capacity = 2**OUT_DEPTH_BITS entries.
- LEN_WIDTH, 32, width of ctx_length and the issue/retire counters.
- TIMEOUT_CYCLES, 1024, drain watchdog limit (only with CONV_CTRL_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- start  in  1  single-cycle pulse; begins a job.
- ctx_length  in  LEN_WIDTH  number of cachelines in the job; sampled on start.
- in_fifo_empty  in  1  input FIFO empty.
- in_fifo_re  out  1  input FIFO pop; also the datapath input_valid.
- dp_output_valid  in  1  datapath produced one result cacheline (output FIFO write).
- out_fifo_count  in  OUT_DEPTH_BITS+1  current output FIFO occupancy, 0..2**OUT_DEPTH_BITS.
- busy  out  1  job in progress (RUN or DRAIN).
- done  out  1  job complete; held until the next accepted start.
- err  out  1  sticky protocol error.
- lines_issued  out  LEN_WIDTH  cachelines popped this job.
- lines_retired  out  LEN_WIDTH  results received this job.
- timeout  out  1  drain watchdog fired (CONV_CTRL_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - All outputs 0.
  - Counters, in-flight count and latched length cleared.
  - Reset mid-job abandons the job; no state is retained.
- State IDLE:
  - start=1 latches ctx_length into len_q, clears counters/err/done.
  - Go to RUN if ctx_length!=0, else DONE on the next cycle.
- State RUN:
  - in_fifo_re is combinational: ~in_fifo_empty & (issued<len_q) & credit_ok.
  - credit_ok = (out_fifo_count + inflight) < 2**OUT_DEPTH_BITS, evaluated at width OUT_DEPTH_BITS+2, no overflow.
  - On each pop: issued+1, inflight+1.
  - The cycle issued reaches len_q, go to DRAIN.
- State DRAIN:
  - in_fifo_re=0.
  - When retired reaches len_q, go to DONE.
- State DONE:
  - done=1, busy=0.
  - start=1 restarts exactly as from IDLE (single-cycle turnaround).
- Retire (any state):
  - dp_output_valid=1 with inflight>0: retired+1, inflight-1.
  - Pop and retire in the same cycle: inflight unchanged, both counters advance.
  - dp_output_valid=1 with inflight==0 (includes IDLE/DONE): set err, counters unchanged.
- start while busy is ignored; no latch, no counter effect.
- err clears only on an accepted start or reset.
- busy = state in {RUN, DRAIN}.
- All outputs are registered except in_fifo_re.
- Latency from the empty→non-empty transition to in_fifo_re: 0 cycles, given credit is available.
- inflight never exceeds 2**OUT_DEPTH_BITS; width is OUT_DEPTH_BITS+1.

Optional Feature:
- Macro: CONV_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counts DRAIN cycles without dp_output_valid and resets on every retire.
  - On reaching TIMEOUT_CYCLES: set timeout and err, go to DONE.
  - timeout clears on an accepted start.
- Undefined:
  - No watchdog logic; timeout tied 0.
  - DRAIN waits indefinitely.

Test Plan:
- Basic job:
  - Stimulus: ctx_length=4, input FIFO holds 4 lines, datapath latency 3, out_fifo_count=0.
  - Response: 4 consecutive in_fifo_re pulses; DRAIN after the 4th; done=1 the cycle after the 4th dp_output_valid; lines_issued=lines_retired=4, err=0.
- Credit stall:
  - Stimulus: OUT_DEPTH_BITS=3, out_fifo_count=6, datapath latency 5, ctx_length=10.
  - Response: at most 2 pops, then in_fifo_re held 0 until the consumer drains; inflight+count never exceeds 8.
- Zero length:
  - Stimulus: start with ctx_length=0.
  - Response: no pops; busy never 1; done=1 two cycles after start.
- Spurious output:
  - Stimulus: dp_output_valid pulse in IDLE.
  - Response: err=1 and stays 1; next start clears it; lines_retired=0.
- Reset mid-job and start while busy:
  - Stimulus: reset low mid-RUN at issued=3.
  - Response: all outputs 0 immediately.
  - Stimulus: start while busy.
  - Response: ignored; len_q unchanged.
- Timeout (CONV_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: withhold the last dp_output_valid.
  - Response: timeout=1, err=1, done=1 after 16 DRAIN cycles.
